// File: rtl/rgb_word_packer.sv
// Packs 24-bit RGB pixels into a 32-bit byte stream (4 pixels -> 3 words),
// with line-end flush of partial words and frame-start marking.
module rgb_word_packer (
  input  logic        aclk,
  input  logic        areset,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic        valid,
  input  logic        sof,
  input  logic        eol,
  output logic        in_stream_ready,
  output logic [31:0] out_stream_tdata,
  output logic [3:0]  out_stream_tkeep,
  output logic        out_stream_tlast,
  output logic        out_stream_tuser,
  output logic        out_stream_tvalid,
  input  logic        out_stream_tready,
  output logic        err_align
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  phase_q, phase_d;
  logic [23:0] buf_q, buf_d;
  logic        sof_pend_q, sof_pend_d;
  logic        err_q, err_d;
  logic [31:0] tdata_q, tdata_d;
  logic [3:0]  tkeep_q, tkeep_d;
  logic        tlast_q, tlast_d;
  logic        tuser_q, tuser_d;
  logic        tvalid_q, tvalid_d;

  logic        out_free;
  logic        accept;
  logic        flush_load;
  logic [1:0]  eff_phase;
  logic        pend_eff;
  logic        ld;
  logic [31:0] w_dat;
  logic [3:0]  w_keep;
  logic        w_last;
  logic        w_user;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next-state logic: only a short line end (phase 1/2) needs an extra flush cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:   if (accept && eol && (eff_phase == 2'd1 || eff_phase == 2'd2)) state_d = FLUSH;
      FLUSH: if (flush_load) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM outputs
  always_comb begin
    out_free        = !tvalid_q || out_stream_tready;
    in_stream_ready = !areset && (state_q == RUN) && out_free;
    accept          = valid && in_stream_ready;
    flush_load      = (state_q == FLUSH) && out_free;
    eff_phase       = sof ? 2'd0 : phase_q;
    pend_eff        = sof || sof_pend_q;
  end

  // Packing datapath; buf_q keeps leftover bytes right-aligned in stream order
  always_comb begin
    phase_d    = phase_q;
    buf_d      = buf_q;
    sof_pend_d = sof_pend_q;
    err_d      = err_q;
    ld         = 1'b0;
    w_dat      = 32'h0;
    w_keep     = 4'hF;
    w_last     = 1'b0;
    w_user     = 1'b0;
    if (accept) begin
      if (sof && phase_q != 2'd0) err_d = 1'b1;
      case (eff_phase)
        2'd0: begin
          if (eol) begin
            ld      = 1'b1;
            w_dat   = {8'h00, b, g, r};
            w_keep  = 4'b0111;
            w_last  = 1'b1;
            err_d   = 1'b1;
            phase_d = 2'd0;
          end else begin
            buf_d   = {b, g, r};
            phase_d = 2'd1;
          end
        end
        2'd1: begin
          ld      = 1'b1;
          w_dat   = {r, buf_q};
          buf_d   = {8'h00, b, g};
          phase_d = 2'd2;
        end
        2'd2: begin
          ld      = 1'b1;
          w_dat   = {g, r, buf_q[15:0]};
          buf_d   = {16'h0000, b};
          phase_d = 2'd3;
        end
        default: begin
          ld      = 1'b1;
          w_dat   = {b, g, r, buf_q[7:0]};
          w_last  = eol;
          phase_d = 2'd0;
        end
      endcase
      if (ld) begin
        w_user     = pend_eff;
        sof_pend_d = 1'b0;
      end else begin
        sof_pend_d = pend_eff;
      end
    end else if (flush_load) begin
      ld         = 1'b1;
      w_dat      = (phase_q == 2'd2) ? {16'h0000, buf_q[15:0]} : {24'h000000, buf_q[7:0]};
      w_keep     = (phase_q == 2'd2) ? 4'b0011 : 4'b0001;
      w_last     = 1'b1;
      w_user     = sof_pend_q;
      sof_pend_d = 1'b0;
      phase_d    = 2'd0;
      err_d      = 1'b1;
    end
  end

  // Single output register stage; payload held while stalled
  always_comb begin
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q;
    if (ld) begin
      tdata_d  = w_dat;
      tkeep_d  = w_keep;
      tlast_d  = w_last;
      tuser_d  = w_user;
      tvalid_d = 1'b1;
    end else if (out_stream_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      phase_q    <= 2'd0;
      buf_q      <= 24'h0;
      sof_pend_q <= 1'b0;
      err_q      <= 1'b0;
      tdata_q    <= 32'h0;
      tkeep_q    <= 4'h0;
      tlast_q    <= 1'b0;
      tuser_q    <= 1'b0;
      tvalid_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      buf_q      <= buf_d;
      sof_pend_q <= sof_pend_d;
      err_q      <= err_d;
      tdata_q    <= tdata_d;
      tkeep_q    <= tkeep_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign out_stream_tdata  = tdata_q;
  assign out_stream_tkeep  = tkeep_q;
  assign out_stream_tlast  = tlast_q;
  assign out_stream_tuser  = tuser_q;
  assign out_stream_tvalid = tvalid_q;
  assign err_align         = err_q;

endmodule

// File: tb/tb_rgb_word_packer.sv
// Directed bench for rgb_word_packer with a byte-stream reference model feeding
// an expected-word queue that is checked on every output handshake.
module tb_rgb_word_packer;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  r = 8'h0, g = 8'h0, b = 8'h0;
  logic        valid = 1'b0, sof = 1'b0, eol = 1'b0;
  logic        in_stream_ready;
  logic [31:0] out_stream_tdata;
  logic [3:0]  out_stream_tkeep;
  logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
  logic        out_stream_tready = 1'b1;
  logic        err_align;

  rgb_word_packer dut (
    .aclk(aclk), .areset(areset), .r(r), .g(g), .b(b),
    .valid(valid), .sof(sof), .eol(eol),
    .in_stream_ready(in_stream_ready),
    .out_stream_tdata(out_stream_tdata), .out_stream_tkeep(out_stream_tkeep),
    .out_stream_tlast(out_stream_tlast), .out_stream_tuser(out_stream_tuser),
    .out_stream_tvalid(out_stream_tvalid), .out_stream_tready(out_stream_tready),
    .err_align(err_align)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
  } wrd_t;

  int   errors = 0;
  int   checks = 0;
  int   words_rx = 0;
  int   lasts_rx = 0;
  int   stalls = 0;
  wrd_t exp_q[$];
  logic [7:0] mb[$];
  logic pend = 1'b0;
  logic err_exp = 1'b0;
  wrd_t held;
  logic held_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: flat byte stream R,G,B per pixel, cut into 4-byte words
  task automatic model_px(input logic [7:0] rr, gg, bb, input logic s, e);
    wrd_t w;
    if (s) begin
      if (mb.size() != 0) err_exp = 1'b1;
      mb.delete();
      pend = 1'b1;
    end
    mb.push_back(rr); mb.push_back(gg); mb.push_back(bb);
    if (mb.size() >= 4) begin
      w.d = {mb[3], mb[2], mb[1], mb[0]};
      repeat (4) void'(mb.pop_front());
      w.k = 4'hF;
      w.l = e && (mb.size() == 0);
      w.u = pend;
      pend = 1'b0;
      exp_q.push_back(w);
    end
    if (e && mb.size() > 0) begin
      err_exp = 1'b1;
      w.d = 32'h0;
      w.k = 4'h0;
      for (int i = 0; i < mb.size(); i++) begin
        w.d[8*i +: 8] = mb[i];
        w.k[i] = 1'b1;
      end
      w.l = 1'b1;
      w.u = pend;
      pend = 1'b0;
      mb.delete();
      exp_q.push_back(w);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the accepting edge
  task automatic px(input logic [7:0] rr, gg, bb, input logic s, e);
    int n;
    r = rr; g = gg; b = bb; sof = s; eol = e; valid = 1'b1;
    n = 0;
    forever begin
      @(negedge aclk);
      if (in_stream_ready) break;
      n++;
      if (n >= 200) break;
    end
    if (n >= 200) begin
      chk("px_accept_timeout", 32'(n), 32'd0);
      valid = 1'b0;
    end else begin
      if (n > 0) stalls++;
      @(posedge aclk); #1;
      valid = 1'b0; sof = 1'b0; eol = 1'b0;
      model_px(rr, gg, bb, s, e);
    end
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin @(posedge aclk); #1; end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    areset = 1'b1; valid = 1'b0; out_stream_tready = 1'b1;
    @(negedge aclk); @(negedge aclk);
    chk("rst_tvalid", {31'd0, out_stream_tvalid}, 32'd0);
    chk("rst_tdata", out_stream_tdata, 32'd0);
    chk("rst_tkeep", {28'd0, out_stream_tkeep}, 32'd0);
    chk("rst_tlast_tuser", {30'd0, out_stream_tlast, out_stream_tuser}, 32'd0);
    chk("rst_err", {31'd0, err_align}, 32'd0);
    chk("rst_ready", {31'd0, in_stream_ready}, 32'd0);
    exp_q.delete(); mb.delete(); pend = 1'b0; err_exp = 1'b0;
    areset = 1'b0;
    #1;
    chk("ready_after_release", {31'd0, in_stream_ready}, 32'd1);
    @(posedge aclk); #1;
  endtask

  // Output monitor: scoreboard compare on handshake, stability while stalled
  always @(negedge aclk) begin
    if (areset) begin
      held_vld = 1'b0;
    end else begin
      wrd_t cur;
      wrd_t e;
      cur = {out_stream_tdata, out_stream_tkeep, out_stream_tlast, out_stream_tuser};
      if (out_stream_tvalid && held_vld) begin
        checks++;
        assert (cur === held) else begin
          errors++;
          $error("FAIL hold_stable observed=%h expected=%h", cur, held);
        end
      end
      if (out_stream_tvalid && out_stream_tready) begin
        words_rx++;
        if (out_stream_tlast) lasts_rx++;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_word observed=%h expected=none", cur);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checks++;
          assert (cur === e) else begin
            errors++;
            $error("FAIL word observed=%h expected=%h", cur, e);
          end
        end
      end
      held_vld = out_stream_tvalid && !out_stream_tready;
      held = cur;
    end
  end

  initial begin
    int wb, lb;

    // Reset values and aligned packing with latency checks
    do_reset();
    px(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    chk("al_no_word_phase0", {31'd0, out_stream_tvalid}, 32'd0);
    px(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    chk("al_w0_valid", {31'd0, out_stream_tvalid}, 32'd1);
    chk("al_w0_data", out_stream_tdata, 32'h04030201);
    chk("al_w0_user", {31'd0, out_stream_tuser}, 32'd1);
    px(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    chk("al_w1_data", out_stream_tdata, 32'h08070605);
    px(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
    chk("al_w2_data", out_stream_tdata, 32'h0C0B0A09);
    chk("al_w2_last", {31'd0, out_stream_tlast}, 32'd1);
    idle(4);
    chk("al_err", {31'd0, err_align}, {31'd0, err_exp});

    // Backpressure after the first word
    do_reset();
    px(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
    px(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    out_stream_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("bp_ready_low", {31'd0, in_stream_ready}, 32'd0);
      chk("bp_hold_data", out_stream_tdata, 32'h04030201);
    end
    @(posedge aclk); #1;
    out_stream_tready = 1'b1;
    px(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
    px(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b1);
    idle(4);

    // Line ends after the third pixel: flush a single residual byte
    do_reset();
    px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    px(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    px(8'h07, 8'h08, 8'h09, 1'b0, 1'b1);
    chk("me_full_data", out_stream_tdata, 32'h08070605);
    chk("me_full_last", {31'd0, out_stream_tlast}, 32'd0);
    chk("me_ready_flush", {31'd0, in_stream_ready}, 32'd0);
    @(posedge aclk); #1;
    chk("me_resid_data", out_stream_tdata, 32'h00000009);
    chk("me_resid_keep", {28'd0, out_stream_tkeep}, 32'h1);
    idle(3);
    chk("me_err", {31'd0, err_align}, {31'd0, err_exp});

    // Line end after one pixel (sof+eol) and after two pixels
    do_reset();
    px(8'hA1, 8'hA2, 8'hA3, 1'b1, 1'b1);
    chk("se_keep", {28'd0, out_stream_tkeep}, 32'h7);
    px(8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
    px(8'hC1, 8'hC2, 8'hC3, 1'b0, 1'b1);
    idle(4);
    chk("se_err", {31'd0, err_align}, 32'd1);

    // sof arriving mid-word discards the partial bytes
    do_reset();
    px(8'hE1, 8'hE2, 8'hE3, 1'b0, 1'b0);
    px(8'hE4, 8'hE5, 8'hE6, 1'b0, 1'b0);
    px(8'h11, 8'h22, 8'h33, 1'b1, 1'b0);
    px(8'h44, 8'h55, 8'h66, 1'b0, 1'b0);
    chk("ms_first_data", out_stream_tdata, 32'h44332211);
    chk("ms_first_user", {31'd0, out_stream_tuser}, 32'd1);
    px(8'h77, 8'h88, 8'h99, 1'b0, 1'b0);
    px(8'hAA, 8'hBB, 8'hCC, 1'b0, 1'b0);
    idle(4);
    chk("ms_err", {31'd0, err_align}, 32'd1);

    // Reset in the middle of a word
    do_reset();
    px(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    px(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
    chk("rm_tvalid_before", {31'd0, out_stream_tvalid}, 32'd1);
    areset = 1'b1;
    #1;
    chk("rm_tvalid_async", {31'd0, out_stream_tvalid}, 32'd0);
    do_reset();
    wb = words_rx;
    px(8'h21, 8'h22, 8'h23, 1'b1, 1'b0);
    px(8'h24, 8'h25, 8'h26, 1'b0, 1'b0);
    px(8'h27, 8'h28, 8'h29, 1'b0, 1'b0);
    px(8'h2A, 8'h2B, 8'h2C, 1'b0, 1'b1);
    idle(4);
    chk("rm_word_count", 32'(words_rx - wb), 32'd3);

    // Sustained 640-pixel line
    do_reset();
    wb = words_rx; lb = lasts_rx; stalls = 0;
    for (int i = 0; i < 640; i++) begin
      px(8'(i), 8'(i + 1), 8'(i + 2), i == 0, i == 639);
    end
    idle(4);
    chk("tp_stalls", 32'(stalls), 32'd0);
    chk("tp_words", 32'(words_rx - wb), 32'd480);
    chk("tp_lasts", 32'(lasts_rx - lb), 32'd1);
    chk("tp_err", {31'd0, err_align}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_word_packer.md
RGB_WORD_PACKER -- requirements
Module: rgb_word_packer

Interface
- REQ-001 The module SHALL have no parameters; pixel format is fixed at 24-bit RGB and the output word at 32 bits.
- REQ-002 aclk  in  1  sole clock; all state changes on its rising edge.
- REQ-003 areset  in  1  asynchronous, active-high reset; one clock and an asynchronous active-high reset is the decided clocking scheme.
- REQ-004 r, g, b  in  8 each  pixel colour from the colour stage.
- REQ-005 valid  in  1  pixel on r/g/b/sof/eol is valid.
- REQ-006 sof  in  1  pixel is the first of a frame.
- REQ-007 eol  in  1  pixel is the last of a line.
- REQ-008 in_stream_ready  out  1  block accepts the presented pixel this cycle.
- REQ-009 out_stream_tdata  out  32  packed byte data.
- REQ-010 out_stream_tkeep  out  4  byte-lane valid mask.
- REQ-011 out_stream_tlast  out  1  word ends a line.
- REQ-012 out_stream_tuser  out  1  word starts a frame.
- REQ-013 out_stream_tvalid  out  1  output word valid.
- REQ-014 out_stream_tready  in  1  downstream accepts the word.
- REQ-015 err_align  out  1  sticky flag for a misaligned sof or eol.

Function
- REQ-016 A pixel SHALL be accepted when valid && in_stream_ready at a clock edge.
- REQ-017 Byte-stream order per pixel n SHALL be: byte 3n = R, byte 3n+1 = G, byte 3n+2 = B.
- REQ-018 Stream byte k SHALL occupy word k/4, lane k%4, which is tdata bits [8*(k%4)+7 : 8*(k%4)].
- REQ-019 A 2-bit phase counter SHALL count accepted pixels 0..3 and wrap 3->0.
- REQ-020 Phase behaviour SHALL be:
  - phase 0: buffer the pixel, no word emitted;
  - phase 1: emit {p1R,p0B,p0G,p0R};
  - phase 2: emit {p2G,p2R,p1B,p1G};
  - phase 3: emit {p3B,p3G,p3R,p2B}.
- REQ-021 An emitted word SHALL appear on the outputs with tvalid=1 in the cycle after the completing pixel is accepted (latency 1).
- REQ-022 The output SHALL be a single register stage with in_stream_ready = (state==RUN) && (!out_stream_tvalid || out_stream_tready).
- REQ-023 A word handshakes on tvalid && tready; tdata, tkeep, tlast and tuser SHALL be held stable while tvalid && !tready.
- REQ-024 Simultaneous output drain and new word load SHALL be supported with no bubble.
- REQ-025 The FSM SHALL have two states, RUN and FLUSH.
- REQ-026 eol at phase 3: the emitted word SHALL carry tlast=1, and phase returns to 0.
- REQ-027 eol at phase 0: a word {8'h00,p0B,p0G,p0R} SHALL be emitted immediately with tkeep=4'b0111 and tlast=1; phase stays 0; err_align is set.
- REQ-028 eol at phase 1 or 2: the full word SHALL be emitted normally with tlast=0, and the FSM enters FLUSH holding the residual bytes.
- REQ-029 In FLUSH: in_stream_ready=0; once the output register is free, load the residual word with tlast=1 and return to RUN with phase 0; err_align is set.
  - phase-1 residual: {16'h0,p1B,p1G}, tkeep=4'b0011;
  - phase-2 residual: {24'h0,p2B}, tkeep=4'b0001.
- REQ-030 All full words SHALL carry tkeep=4'b1111.
- REQ-031 sof at phase 0 SHALL set a pending flag, so that the next word emitted carries tuser=1; the flag then clears.
- REQ-032 sof at phase != 0 SHALL discard the buffered partial bytes (no word emitted for them), treat the pixel as phase 0 with sof pending, and set err_align.
- REQ-033 sof and eol on the same pixel SHALL apply both rules, so a phase-0 sof+eol word carries tuser=1, tlast=1, tkeep=4'b0111.
- REQ-034 err_align SHALL remain set until reset.

Reset
- REQ-035 While areset=1, the block SHALL hold: out_stream_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, err_align=0, in_stream_ready=0, phase=0, state=RUN, sof-pending=0.
- REQ-036 Reset asserted mid-word or mid-FLUSH SHALL drop all buffered bytes, and tvalid SHALL deassert asynchronously.
- REQ-037 After reset release, in_stream_ready SHALL be 1 at the first clock edge.

Verification
- REQ-038 Aligned packing: pixels (01,02,03),(04,05,06),(07,08,09),(0A,0B,0C), sof on the first and eol on the fourth, tready=1 -> words 0x04030201 (tuser=1), 0x08070605, 0x0C0B0A09 (tlast=1), all tkeep=F, each one cycle after its completing pixel.
- REQ-039 Backpressure: same stimulus with tready=0 for 5 cycles after the first word -> word 0x04030201 held stable, in_stream_ready=0, no word lost or duplicated after tready=1.
- REQ-040 Misaligned eol at phase 2: pixels (01,02,03),(04,05,06),(07,08,09) with eol on the third -> 0x04030201, 0x08070605 (tlast=0), then 0x00000009 with tkeep=1 and tlast=1; ready=0 during FLUSH; err_align=1.
- REQ-041 Misaligned sof: two pixels, then a sof pixel (11,22,33) followed by three more pixels -> first word 0x??332211 carries tuser=1; the two earlier pixels emit nothing; err_align=1.
- REQ-042 Reset mid-operation: assert areset after two pixels with tvalid=1 -> tvalid=0 immediately; a following aligned 4-pixel group produces exactly 3 correct words.
- REQ-043 Sustained throughput: 640 pixels/line, tready=1 -> 480 words per line, tlast only on word 480, and in_stream_ready held at 1 continuously.
